// File: rtl/dcache_nway.sv
// WAYS-way set-associative write-back/write-allocate data cache with tree pseudo-LRU replacement.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_nway #(
  parameter int S_INDEX = 3,
  parameter int WAYS    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);
  localparam int S_OFFSET = 5;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int SETS     = 2 ** S_INDEX;
  localparam int W_BITS   = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t              state;
  logic [S_TAG-1:0]    tag_q   [SETS][WAYS];
  logic [255:0]        data_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-2:0]     plru_q  [SETS];
  logic [W_BITS-1:0]   victim_q;
  logic                pmem_read_q;
  logic                pmem_write_q;

  logic [S_TAG-1:0]    tag;
  logic [S_INDEX-1:0]  idx;
  logic                req;
  logic                hit;
  logic [W_BITS-1:0]   hit_way;
  logic [W_BITS-1:0]   vic_way;
  logic                vic_found;
  logic                hit_ok;
  logic                unused_offset;

  assign tag           = mem_address[31:S_OFFSET+S_INDEX];
  assign idx           = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req           = mem_read | mem_write;
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] cur,
                                                 input logic [W_BITS-1:0] way);
    logic [WAYS-2:0] nxt;
    int unsigned     node;
    logic            b;
    nxt  = cur;
    node = 0;
    for (int unsigned lvl = 0; lvl < W_BITS; lvl++) begin
      b         = way[W_BITS-1-lvl];
      nxt[node] = ~b;
      node      = 2 * node + 1 + 32'(b);
    end
    return nxt;
  endfunction

  function automatic logic [255:0] merge_bytes(input logic [255:0] old,
                                               input logic [255:0] wd,
                                               input logic [31:0]  be);
    logic [255:0] res;
    res = old;
    for (int unsigned i = 0; i < 32; i++)
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = w[W_BITS-1:0];
      end
    end
  end

  always_comb begin
    int unsigned node;
    logic        b;
    node      = 0;
    b         = 1'b0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[idx][w]) begin
        vic_way   = w[W_BITS-1:0];
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int unsigned lvl = 0; lvl < W_BITS; lvl++) begin
        b                      = plru_q[idx][node];
        vic_way[W_BITS-1-lvl]  = b;
        node                   = 2 * node + 1 + 32'(b);
      end
    end
  end

  assign hit_ok       = (state == IDLE) && req && hit;
  assign mem_resp     = hit_ok & rst;
  assign mem_rdata256 = data_q[idx][hit_way];
  assign pmem_read    = pmem_read_q & rst;
  assign pmem_write   = pmem_write_q & rst;
  assign pmem_wdata   = data_q[idx][victim_q];
  assign pmem_address = (state == WB) ? {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}}
                                      : {tag, idx, {S_OFFSET{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      victim_q     <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (mem_write) begin
              data_q[idx][hit_way]  <= merge_bytes(data_q[idx][hit_way], mem_wdata256,
                                                   mem_byte_enable256);
              dirty_q[idx][hit_way] <= 1'b1;
            end
          end else if (req) begin
            victim_q <= vic_way;
            if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
              state        <= WB;
              pmem_write_q <= 1'b1;
            end else begin
              state       <= FILL;
              pmem_read_q <= 1'b1;
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            dirty_q[idx][victim_q] <= 1'b0;
            pmem_write_q           <= 1'b0;
            pmem_read_q            <= 1'b1;
            state                  <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            data_q[idx][victim_q]  <= pmem_rdata;
            tag_q[idx][victim_q]   <= tag;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            pmem_read_q            <= 1'b0;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        retry_q;

  // retry_q marks the completion of a request that already counted as a miss.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q   <= '0;
      miss_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      if (state == IDLE && req && !hit && miss_q != '1)
        miss_q <= miss_q + 32'd1;
      if (state == FILL && pmem_resp)
        retry_q <= 1'b1;
      if (mem_resp) begin
        retry_q <= 1'b0;
        if (!retry_q && hit_q != '1)
          hit_q <= hit_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Directed self-checking bench for dcache_nway (S_INDEX=3, WAYS=4) with a fixed-latency memory model.
module tb_dcache_nway;
  localparam int MEM_LAT = 2;
`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem_model [logic [31:0]];
  int           lat_cnt = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  bit           mem_en = 1'b1;

  dcache_nway #(.S_INDEX(3), .WAYS(4)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
    .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat(a);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers MEM_LAT cycles after a request is first seen.
  always begin
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    checks++;
    assert (!(pmem_read && pmem_write)) else begin
      errors++;
      $error("FAIL pmem_excl: observed read=%0b write=%0b expected not both high", pmem_read, pmem_write);
    end
    if (mem_en && (pmem_read || pmem_write)) begin
      if (lat_cnt == MEM_LAT) begin
        lat_cnt   = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          mem_model[pmem_address] = pmem_wdata;
          wr_cnt++;
          last_wb_addr = pmem_address;
          last_wb_data = pmem_wdata;
        end else begin
          pmem_rdata = line_of(pmem_address);
          rd_cnt++;
          last_rd_addr = pmem_address;
        end
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] be,
                        input logic [255:0] wd, output logic [255:0] rd, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    rd   = '0;
    mem_address        = addr;
    mem_read           = !wr;
    mem_write          = wr;
    mem_byte_enable256 = be;
    mem_wdata256       = wd;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (mem_resp) begin
        rd   = mem_rdata256;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) cyc++;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!done) chk("access_timeout", 256'(addr), 256'hFFFF_FFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rd;
    logic [255:0] merged;
    logic [31:0]  set2 [4];
    int           cyc;
    int           n;
    int           rd_before;
    bit           saw_resp;

    set2 = '{32'h040, 32'h140, 32'h240, 32'h340};
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_byte_enable256 = '0; mem_wdata256 = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_resp", 256'(mem_resp), 256'd0);
    chk("rst_pmem_read", 256'(pmem_read), 256'd0);
    chk("rst_pmem_write", 256'(pmem_write), 256'd0);
    chk("rst_hit_count", 256'(hit_count), 256'd0);
    chk("rst_miss_count", 256'(miss_count), 256'd0);
    rst = 1'b1;

    // Cold read miss
    access(1'b0, 32'h40, '0, '0, rd, cyc);
    chk("fill_addr", 256'(last_rd_addr), 256'h40);
    chk("fill_data", rd, pat(32'h40));
    chk("clean_miss_lat", 256'(cyc), 256'(2 + MEM_LAT));
    chk("miss_count_1", 256'(miss_count), PERF ? 256'd1 : 256'd0);
    chk("hit_count_0", 256'(hit_count), 256'd0);

    // Write hit with byte enables, then read back
    merged = pat(32'h40);
    merged[31:0] = 32'hDEADBEEF;
    access(1'b1, 32'h40, 32'h0000_000F, {8{32'hDEADBEEF}}, rd, cyc);
    chk("write_hit_lat", 256'(cyc), 256'd0);
    access(1'b0, 32'h40, '0, '0, rd, cyc);
    chk("read_hit_lat", 256'(cyc), 256'd0);
    chk("merged_data", rd, merged);
    chk("hit_no_fill", 256'(rd_cnt), 256'd1);
    chk("hit_no_wb", 256'(wr_cnt), 256'd0);

    // Fill the rest of set 2, then touch ways 0..3
    for (int i = 1; i < 4; i++) begin
      access(1'b0, set2[i], '0, '0, rd, cyc);
      chk("set2_fill_lat", 256'(cyc), 256'(2 + MEM_LAT));
      chk("set2_fill_data", rd, pat(set2[i]));
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b0, set2[i], '0, '0, rd, cyc);
      chk("touch_lat", 256'(cyc), 256'd0);
      chk("touch_data", rd, (i == 0) ? merged : pat(set2[i]));
    end

    // PLRU victim is way 0 (dirty 0x40): write-back then fill
    access(1'b0, 32'h440, '0, '0, rd, cyc);
    chk("dirty_miss_lat", 256'(cyc), 256'(3 + 2 * MEM_LAT));
    chk("wb_count", 256'(wr_cnt), 256'd1);
    chk("wb_addr", 256'(last_wb_addr), 256'h40);
    chk("wb_data", last_wb_data, merged);
    chk("dirty_fill_data", rd, pat(32'h440));

    // Tree now points at way 2 (0x240); 0x40 returns from memory with merged bytes
    access(1'b0, 32'h40, '0, '0, rd, cyc);
    chk("refetch_lat", 256'(cyc), 256'(2 + MEM_LAT));
    chk("refetch_data", rd, merged);
    access(1'b0, 32'h240, '0, '0, rd, cyc);
    chk("evicted_way2_lat", 256'(cyc), 256'(2 + MEM_LAT));
    chk("no_extra_wb", 256'(wr_cnt), 256'd1);

    // Drop the request mid-fill
    rd_before = rd_cnt;
    mem_address = 32'h60;
    mem_read = 1'b1;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drop_fill_started", 256'(pmem_read), 256'd1);
    mem_read = 1'b0;
    saw_resp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_resp) saw_resp = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("drop_no_resp", 256'(saw_resp), 256'd0);
    chk("drop_fill_done", 256'(rd_cnt), 256'(rd_before + 1));
    chk("drop_pmem_idle", 256'(pmem_read), 256'd0);
    access(1'b0, 32'h60, '0, '0, rd, cyc);
    chk("drop_rereq_lat", 256'(cyc), 256'd0);
    chk("drop_rereq_data", rd, pat(32'h60));
    chk("hit_count_mid", 256'(hit_count), PERF ? 256'd6 : 256'd0);
    chk("miss_count_mid", 256'(miss_count), PERF ? 256'd8 : 256'd0);

    // Reset in the middle of a fill
    mem_en = 1'b0;
    mem_address = 32'h80;
    mem_read = 1'b1;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rstfill_started", 256'(pmem_read), 256'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstfill_pmem_read", 256'(pmem_read), 256'd0);
    chk("rstfill_mem_resp", 256'(mem_resp), 256'd0);
    mem_read = 1'b0;
    rst = 1'b1;
    mem_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rstfill_idle", 256'(pmem_read | pmem_write), 256'd0);
    chk("rst2_hit_count", 256'(hit_count), 256'd0);
    chk("rst2_miss_count", 256'(miss_count), 256'd0);
    access(1'b0, 32'h40, '0, '0, rd, cyc);
    chk("post_rst_miss_lat", 256'(cyc), 256'(2 + MEM_LAT));
    chk("post_rst_data", rd, merged);

    // Counter scenario: 3 misses, 10 hits
    access(1'b0, 32'h140, '0, '0, rd, cyc);
    access(1'b0, 32'h240, '0, '0, rd, cyc);
    for (int i = 0; i < 10; i++) begin
      access(1'b0, set2[i % 3], '0, '0, rd, cyc);
      chk("cnt_hit_lat", 256'(cyc), 256'd0);
    end
    chk("final_hit_count", 256'(hit_count), PERF ? 256'd10 : 256'd0);
    chk("final_miss_count", 256'(miss_count), PERF ? 256'd3 : 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised WAYS-way set-associative write-back, write-allocate data cache between the CPU bus adaptor (256-bit line interface with 32-bit byte enables) and the cacheline adaptor to physical memory. It contains its own tag, valid, dirty and data storage, a tree pseudo-LRU replacement policy per set, and the miss/write-back controller FSM. It generalises the 2-way true-LRU dcache datapath to any power-of-two associativity.

## Interface
- S_INDEX, 3: set-index bits; sets = 2**S_INDEX.
- WAYS, 4: associativity, power of two, ≥2.
- Derived, not overridable: S_OFFSET = 5 (256-bit line); S_TAG = 32 − S_OFFSET − S_INDEX.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- mem_address  in  32  CPU byte address; bits [4:0] ignored.
- mem_read  in  1  read request, held until mem_resp.
- mem_write  in  1  write request, held until mem_resp.
- mem_byte_enable256  in  32  per-byte write enable.
- mem_wdata256  in  256  write data.
- mem_rdata256  out  256  hit line data, valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned memory address; [4:0]=0.
- pmem_read  out  1  line fill request, held until pmem_resp.
- pmem_write  out  1  line write-back request, held until pmem_resp.
- pmem_wdata  out  256  victim line data.
- pmem_rdata  in  256  fill data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.
- hit_count  out  32  hit counter (see Configuration).
- miss_count  out  32  miss counter (see Configuration).

## Operation
- Storage: per set and per way, tag[S_TAG], valid, dirty, data[256]. Per set, plru[WAYS−1]. All storage is flop-based and read combinationally.
- Lookup: tag = addr[31:S_OFFSET+S_INDEX], index = addr[S_OFFSET+S_INDEX−1:S_OFFSET]. Way w hits if valid[w] and tag[w]==tag. At most one way hits.
- FSM states:
  - IDLE, hit: mem_resp=1 in the same cycle.
    - Read: mem_rdata256 = hit line.
    - Write: bytes with enable=1 merged into the line at the edge; dirty set.
    - PLRU updated so that the accessed way is most-recent.
  - IDLE, miss: select victim.
    - Victim is the lowest-numbered invalid way; if all ways are valid, the way pointed to by the PLRU tree.
    - Victim valid and dirty → WB; otherwise → FILL. Victim is latched on leaving IDLE.
  - WB: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim data. On pmem_resp: clear dirty, → FILL.
  - FILL: pmem_read=1, pmem_address={tag, index, 5'b0}. On pmem_resp: write pmem_rdata into the victim way, set tag, valid=1, dirty=0, → IDLE.
  - Returning to IDLE: the held request now hits and completes through the normal hit path.
- PLRU: tree bit=0 points to the lower half. Access flips the node bits on the path to point away from the accessed way. Fill alone does not update PLRU; the following hit does.
- mem_read and mem_write both high: treated as a write.
- Request dropped during WB/FILL: the miss sequence still completes and the line is installed; no mem_resp is issued.
- mem_address must be stable from request until mem_resp. Changing it mid-miss is a protocol violation; the behaviour for that case is undefined.

## Timing
- Hit latency: 0 cycles; mem_resp is combinational in the request cycle.
- Clean miss: 1 (IDLE) + fill cycles until pmem_resp + 1 (IDLE hit).
- Dirty miss: adds the WB cycles until its pmem_resp.
- pmem_read and pmem_write are never high together. Each drops in the cycle after pmem_resp is sampled.
- Reset (rst=0 at an edge) takes effect from any state, including mid-WB/FILL:
  - State → IDLE.
  - All valid, dirty and plru bits → 0; tag and data contents are unspecified.
  - Counters → 0.
  - Outputs while in reset: mem_resp=0, pmem_read=0, pmem_write=0.
  - An outstanding memory transaction is abandoned.

## Configuration
- DCACHE_PERF_CNT_EN defined:
  - miss_count increments on each IDLE→WB/FILL transition.
  - hit_count increments on each mem_resp not preceded by a miss for that request; a retry flag is set at FILL completion and cleared at mem_resp.
  - Both counters saturate at 32'hFFFF_FFFF.
- Macro not defined: counter logic is absent; hit_count and miss_count are tied to 0.

## Test plan
- After reset, read 0x0000_0040 → FILL with pmem_address 0x0000_0040. Return line A on pmem_resp → mem_resp with mem_rdata256=A, 1 cycle after FILL exits. miss_count=1, hit_count=0.
- Write 0xDEADBEEF at bytes 0–3 (byte_enable 0x0000000F) to the resident line → mem_resp in the same cycle. A following read returns the merged line; no pmem activity.
- With WAYS=4, fill 4 distinct tags in set 2, touch ways 0,1,2,3, then miss in set 2 → victim is way 0 per the PLRU tree. The dirty victim is written back to its own address before the fill.
- Assert rst=0 during FILL with pmem_read high → next cycle pmem_read=0, state IDLE. A subsequent read of the previously resident address misses.
- Drop mem_read mid-FILL → line still installed, no mem_resp. A re-request hits with 0 latency.
- With DCACHE_PERF_CNT_EN: 10 hits and 3 misses → hit_count=10, miss_count=3. Without the macro, both read 0.
